servo_pwm_gen: RTL and testbench
================================

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning the system clock frequency in Hz; it SHALL be an integer multiple of 1_000_000.
REQ-002 The block SHALL have parameter FRAME_US, default 20000, meaning the servo frame period in microseconds (max 32767).
REQ-003 The block SHALL have parameter SLEW_US, default 20, meaning the maximum change of pulse width per frame in microseconds (used only under REQ-021).
REQ-004 Port clk, input, 1 bit: system clock; the block SHALL use this single clock and no other.
REQ-005 Port rst, input, 1 bit: reset; it SHALL be synchronous and active-high.
REQ-006 Port pos_us, input, 11 bits: requested pulse width in microseconds (joystick value already offset by +1000).
REQ-007 Port pos_valid, input, 1 bit: one-cycle strobe qualifying pos_us.
REQ-008 Port pwm, output, 1 bit: registered servo PWM output.
REQ-009 Port frame_start, output, 1 bit: one-cycle pulse marking the start of a new frame.
REQ-010 Port width_us, output, 11 bits: pulse width currently being generated, for debug display.

Function
REQ-011 The prescaler SHALL count 0..DIV-1, where DIV = CLK_FREQ_HZ/1_000_000, and SHALL assert us_tick in the cycle it holds DIV-1; with DIV=1, us_tick SHALL be high every cycle.
REQ-012 The 15-bit us_cnt SHALL advance on us_tick and SHALL wrap from FRAME_US-1 to 0.
REQ-013 frame_start SHALL be high for exactly the one clock cycle following the wrap of us_cnt to 0.
REQ-014 On pos_valid, the pending register SHALL load clamp(pos_us) = MIN_US if pos_us < 1000, MAX_US if pos_us > 2000, else pos_us.
REQ-015 The active width SHALL update only in the cycle in which us_cnt wraps; the block SHALL never alter a pulse mid-frame.
REQ-016 If pos_valid coincides with the wrap cycle, the active width SHALL take the old pending value, and the new value SHALL apply from the next frame.
REQ-017 Multiple pos_valid strobes within one frame SHALL result in the last value winning.
REQ-018 pwm SHALL be registered as (us_cnt < active width), giving one clock of latency relative to us_cnt.
REQ-019 width_us SHALL equal the active width at all times.

Reset
REQ-020 While rst is high: prescaler, us_cnt = 0; pending = active = 1500 (CENTER_US); pwm = 0; frame_start = 0; width_us = 1500. The first frame SHALL start the cycle after rst falls, and the pulse SHALL be 1500 us. Reset asserted mid-pulse SHALL force pwm low on the next edge.

Configuration
REQ-021 With SERVO_SLEW_LIMIT_EN defined, the active width SHALL step at each wrap toward pending by min(|pending-active|, SLEW_US) and SHALL stop exactly at pending with no overshoot.
REQ-022 With SERVO_SLEW_LIMIT_EN undefined, the active width SHALL equal pending at each wrap, and SLEW_US SHALL be ignored.

Structure
REQ-023 Package servo_pkg SHALL hold MIN_US = 1000, MAX_US = 2000, CENTER_US = 1500 and typedef pulse_us_t (logic [10:0]); the block SHALL import the package.
REQ-024 The prescaler SHALL be the sub-module servo_us_prescaler (clk, rst, us_tick, with parameter DIV); all other logic SHALL be in servo_pwm_gen.

Verification
(All scenarios use CLK_FREQ_HZ = 2_000_000 and FRAME_US = 100 unless stated otherwise.)
REQ-025 Release reset with no input -> pwm high for 1500 us of a 20000 us frame with default FRAME_US; width_us = 1500; frame_start period = 40000 clocks at the test clock.
REQ-026 pos_us = 2047 strobed -> width_us = 2000 after the next wrap; pos_us = 200 strobed -> width_us = 1000 after the following wrap.
REQ-027 pos_valid with pos_us = 1200 in the same cycle as the wrap -> the current frame keeps the old width, and the next frame is 1200 us.
REQ-028 pos_us = 1100, then 1900, then 1300 strobed within one frame -> the next frame is 1300 us; no frame shows 1100 or 1900.
REQ-029 With SERVO_SLEW_LIMIT_EN defined, pos_us = 1590 from reset -> widths of successive frames are 1520, 1540, 1560, 1580, 1590, 1590.
REQ-030 rst pulsed for one cycle at us_cnt = 700 with pwm high -> pwm = 0 on the next edge, width_us = 1500, and a new frame starts the cycle after rst falls.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared pulse-width type and limits for the servo PWM block
package servo_pkg;
    typedef logic [10:0] pulse_us_t;
    localparam pulse_us_t MIN_US    = 11'd1000;
    localparam pulse_us_t MAX_US    = 11'd2000;
    localparam pulse_us_t CENTER_US = 11'd1500;
endpackage

// File: rtl/servo_us_prescaler.sv
// servo_us_prescaler: divides clk down to a one-cycle tick every microsecond
module servo_us_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic us_tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        cnt <= (rst || cnt == W'(DIV - 1)) ? '0 : cnt + W'(1);
    end
    assign us_tick = !rst && cnt == W'(DIV - 1);
endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: frame-synchronous servo PWM generator with clamped pulse width
// Build option SERVO_SLEW_LIMIT_EN: limit width change per frame to SLEW_US.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FRAME_US    = 20000,
    parameter int SLEW_US     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pos_us,
    input  logic        pos_valid,
    output logic        pwm,
    output logic        frame_start,
    output logic [10:0] width_us
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    if (CLK_FREQ_HZ % 1_000_000 != 0 || DIV < 1 || FRAME_US < 1 || FRAME_US > 32767 || SLEW_US < 1) begin : g_bad_cfg
        $error("servo_pwm_gen: invalid parameters");
    end
    logic        us_tick, first_q, wrap;
    logic [14:0] us_cnt;
    pulse_us_t   pending, active, clamped, next_active;
    // The cycle after reset is held as microsecond zero so the first frame is full length.
    servo_us_prescaler #(.DIV(DIV)) u_presc (
        .clk(clk),
        .rst(rst | first_q),
        .us_tick(us_tick)
    );
    assign wrap     = us_tick && us_cnt == 15'(FRAME_US - 1);
    assign clamped  = pos_us < MIN_US ? MIN_US : pos_us > MAX_US ? MAX_US : pos_us;
    assign width_us = active;
`ifdef SERVO_SLEW_LIMIT_EN
    localparam pulse_us_t SLEW = pulse_us_t'(SLEW_US);
    assign next_active = pending > active
        ? (pending - active > SLEW ? active + SLEW : pending)
        : (active - pending > SLEW ? active - SLEW : pending);
`else
    assign next_active = pending;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q     <= 1'b1;
            us_cnt      <= '0;
            pending     <= CENTER_US;
            active      <= CENTER_US;
            pwm         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            first_q     <= 1'b0;
            if (us_tick) us_cnt <= wrap ? '0 : us_cnt + 15'd1;
            if (pos_valid) pending <= clamped;
            if (wrap) active <= next_active;
            pwm         <= us_cnt < 15'(active);
            frame_start <= wrap | first_q;
        end
    end
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed checks of servo_pwm_gen (small frame and default frame instances)
module tb_servo_pwm_gen;
    logic        clk = 1'b0;
    logic        s_rst, s_pos_valid, s_pwm, s_fs;
    logic [10:0] s_pos_us, s_width;
    logic        d_rst, d_pos_valid, d_pwm, d_fs;
    logic [10:0] d_pos_us, d_width;
    int vecs = 0, errs = 0;
    int n, hi, period;

    always #5 clk = ~clk;

    servo_pwm_gen #(.CLK_FREQ_HZ(2_000_000), .FRAME_US(100)) u_s (
        .clk(clk), .rst(s_rst), .pos_us(s_pos_us), .pos_valid(s_pos_valid),
        .pwm(s_pwm), .frame_start(s_fs), .width_us(s_width)
    );
    servo_pwm_gen #(.CLK_FREQ_HZ(2_000_000)) u_d (
        .clk(clk), .rst(d_rst), .pos_us(d_pos_us), .pos_valid(d_pos_valid),
        .pwm(d_pwm), .frame_start(d_fs), .width_us(d_width)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [10:0] v);
        s_pos_us = v;
        s_pos_valid = 1'b1;
        step(1);
        s_pos_valid = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int c;
        c = 0;
        do begin
            step(1);
            c++;
        end while (!s_fs && c < 400);
        chk(tag, s_fs, 1);
    endtask

    initial begin
        s_rst = 1'b1; d_rst = 1'b1;
        s_pos_valid = 1'b0; d_pos_valid = 1'b0;
        s_pos_us = 11'd0; d_pos_us = 11'd0;
        step(3);
        chk("rst_pwm", s_pwm, 0);
        chk("rst_fs", s_fs, 0);
        chk("rst_width", s_width, 1500);
        chk("rst_d_width", d_width, 1500);
        s_rst = 1'b0; d_rst = 1'b0;
        step(1);
        chk("first_fs_s", s_fs, 1);
        chk("first_fs_d", d_fs, 1);
        hi = 0; period = 0;
        for (int i = 1; i <= 40001 && period == 0; i++) begin
            step(1);
            if (i <= 40000) hi += int'(d_pwm);
            if (d_fs) period = i;
        end
        chk("frame_period", period, 40000);
        chk("pulse_clocks", hi, 3000);
        chk("idle_width_d", d_width, 1500);
        chk("idle_width_s", s_width, 1500);
        step(1401);
        chk("mid_pulse_pwm", d_pwm, 1);
        d_rst = 1'b1;
        step(1);
        chk("rst_forces_pwm_low", d_pwm, 0);
        chk("rst_pulse_width", d_width, 1500);
        chk("rst_pulse_fs", d_fs, 0);
        d_rst = 1'b0;
        step(1);
        chk("restart_fs", d_fs, 1);
        step(1);
        chk("restart_fs_once", d_fs, 0);
        wait_fs("align");
`ifdef SERVO_SLEW_LIMIT_EN
        strobe(11'd1590);
        wait_fs("slew_f1");  chk("slew_1520", s_width, 1520);
        wait_fs("slew_f2");  chk("slew_1540", s_width, 1540);
        wait_fs("slew_f3");  chk("slew_1560", s_width, 1560);
        wait_fs("slew_f4");  chk("slew_1580", s_width, 1580);
        wait_fs("slew_f5");  chk("slew_1590", s_width, 1590);
        wait_fs("slew_f6");  chk("slew_hold", s_width, 1590);
`else
        strobe(11'd2047);
        chk("no_mid_frame_change", s_width, 1500);
        wait_fs("f_2047");
        chk("clamp_high", s_width, 2000);
        chk("pwm_high", s_pwm, 1);
        strobe(11'd200);
        wait_fs("f_200");
        chk("clamp_low", s_width, 1000);
        step(199);
        chk("pre_wrap_fs", s_fs, 0);
        s_pos_us = 11'd1200;
        s_pos_valid = 1'b1;
        step(1);
        s_pos_valid = 1'b0;
        chk("wrap_fs", s_fs, 1);
        chk("wrap_keeps_old", s_width, 1000);
        wait_fs("f_1200");
        chk("wrap_next_frame", s_width, 1200);
        strobe(11'd1100);
        step(10);
        strobe(11'd1900);
        step(10);
        strobe(11'd1300);
        chk("multi_mid_frame", s_width, 1200);
        wait_fs("f_multi");
        chk("last_wins", s_width, 1300);
        wait_fs("f_multi2");
        chk("last_wins_hold", s_width, 1300);
        strobe(11'd999);
        wait_fs("f_999");
        chk("clamp_999", s_width, 1000);
        strobe(11'd2001);
        wait_fs("f_2001");
        chk("clamp_2001", s_width, 2000);
        strobe(11'd1750);
        step(5);
        s_rst = 1'b1;
        step(1);
        chk("s_rst_width", s_width, 1500);
        s_rst = 1'b0;
        step(1);
        chk("s_restart_fs", s_fs, 1);
        wait_fs("f_after_rst");
        chk("pending_cleared", s_width, 1500);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
